branch_ctrl: RTL and testbench

Branch control unit for the RV32I pipeline. It predicts conditional branches in ID with a 2-bit saturating branch history table (BHT). It resolves them in EX using the RV32I compare rules, and on a misprediction issues a registered redirect plus a timed front-end flush. It sits beside the EX-stage comparator path and drives the fetch PC mux and the IF/ID kill lines.

---
 rtl/branch_pkg.sv | 36 +++
 rtl/branch_ctrl_bht_2bit.sv | 33 +++
 rtl/branch_ctrl.sv | 145 ++++++++++++++
 tb/tb_branch_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared constants, counter encodings and FSM state type for the branch control unit.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Saturating 2-bit history update.
    function automatic logic [1:0] ctr_next(
        input logic [1:0] ctr,
        input logic       taken
    );
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_ctrl_bht_2bit.sv
// Branch history table of 2-bit saturating counters: async read, sync update.
// Every entry resets to weakly not-taken.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX = $clog2(ENTRIES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDX-1:0] i_rd_idx,
    output logic [1:0]     o_rd_ctr,
    input  logic           i_wr_en,
    input  logic [IDX-1:0] i_wr_idx,
    input  logic           i_wr_taken
);

    logic [1:0] r_ctr [ENTRIES];

    // No write-to-read bypass: a same-cycle lookup sees the old counter.
    assign o_rd_ctr = r_ctr[i_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_WNT;
            end
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= ctr_next(r_ctr[i_wr_idx], i_wr_taken);
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch predict/resolve unit: BHT lookup in ID, compare and redirect in EX.
// Define BRANCH_CTRL_BHT_EN to build the BHT; otherwise prediction is static not-taken.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    output logic        id_pred_taken,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic        ex_pred_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic        w_legal;
    logic        w_taken;
    logic        w_accept;
    logic        w_mispred;
    logic [31:0] w_tgt_taken;
    logic [31:0] w_tgt_seq;

    state_t      r_state;
    logic [2:0]  r_flush_cnt;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic        r_flush;
    logic [31:0] r_br_count;
    logic [31:0] r_mispred_count;

    always_comb begin
        w_legal = 1'b1;
        w_taken = 1'b0;
        unique case (1'b1)
            (ex_funct3 == F3_BEQ):  w_taken = (ex_rs1 == ex_rs2);
            (ex_funct3 == F3_BNE):  w_taken = (ex_rs1 != ex_rs2);
            (ex_funct3 == F3_BLT):  w_taken = ($signed(ex_rs1) < $signed(ex_rs2));
            (ex_funct3 == F3_BGE):  w_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            (ex_funct3 == F3_BLTU): w_taken = (ex_rs1 < ex_rs2);
            (ex_funct3 == F3_BGEU): w_taken = (ex_rs1 >= ex_rs2);
            default:                w_legal = 1'b0;
        endcase
    end

    assign w_tgt_taken = ex_pc + ex_imm;
    assign w_tgt_seq   = ex_pc + 32'd4;

    // While flushing, EX holds a wrong-path instruction and is ignored.
    assign w_accept  = (r_state == IDLE) && ex_valid && w_legal;
    assign w_mispred = w_accept && (w_taken != ex_pred_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_flush_cnt      <= 3'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_flush          <= 1'b0;
            r_br_count       <= 32'd0;
            r_mispred_count  <= 32'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_redirect_valid <= 1'b0;
                    if (w_accept) begin
                        if (r_br_count != 32'hFFFF_FFFF) begin
                            r_br_count <= r_br_count + 32'd1;
                        end
                    end
                    if (w_mispred) begin
                        if (r_mispred_count != 32'hFFFF_FFFF) begin
                            r_mispred_count <= r_mispred_count + 32'd1;
                        end
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= w_taken ? w_tgt_taken : w_tgt_seq;
                        r_flush          <= 1'b1;
                        r_flush_cnt      <= FLUSH_LOAD;
                        r_state          <= FLUSH;
                    end
                end
                FLUSH: begin
                    r_redirect_valid <= 1'b0;
                    if (r_flush_cnt == 3'd0) begin
                        r_flush <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_flush;
    assign br_count       = r_br_count;
    assign mispred_count  = r_mispred_count;

`ifdef BRANCH_CTRL_BHT_EN
    localparam int IDX = $clog2(BHT_ENTRIES);

    logic [1:0] w_rd_ctr;

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (id_pc[IDX+1:2]),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (w_accept),
        .i_wr_idx   (ex_pc[IDX+1:2]),
        .i_wr_taken (w_taken)
    );

    assign id_pred_taken = id_valid & w_rd_ctr[1];

    logic w_unused_bits;
    assign w_unused_bits = ^{id_pc[31:IDX+2], id_pc[1:0], w_rd_ctr[0]};
`else
    assign id_pred_taken = 1'b0;

    logic w_unused_bits;
    assign w_unused_bits = ^{id_valid, id_pc, (BHT_ENTRIES > 0)};
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl; expectations follow BRANCH_CTRL_BHT_EN.
module tb_branch_ctrl;

    localparam int ENTRIES = 16;
    localparam int FC      = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic        ex_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  bht_m [ENTRIES];
    logic [31:0] br_m;
    logic [31:0] mis_m;
    int          m_busy;
    logic [31:0] exp_q [$];

    branch_ctrl #(
        .BHT_ENTRIES  (ENTRIES),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pred_taken  (id_pred_taken),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_funct3      (ex_funct3),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_pred_taken  (ex_pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic m_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_pred(input logic [31:0] pc);
`ifdef BRANCH_CTRL_BHT_EN
        return bht_m[pc[5:2]][1];
`else
        return 1'b0 & pc[0];
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) bht_m[i] = 2'b01;
        br_m = 32'd0;
        mis_m = 32'd0;
        m_busy = 0;
        exp_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (m_busy > 0) m_busy--;
    endtask

    task automatic present_br(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] b, input logic pred);
        logic act;
        logic [3:0] ix;
        ex_valid = 1'b1;
        ex_pc = pc;
        ex_imm = imm;
        ex_funct3 = f3;
        ex_rs1 = a;
        ex_rs2 = b;
        ex_pred_taken = pred;
        if (f3 != 3'b010 && f3 != 3'b011 && m_busy == 0) begin
            act = m_taken(f3, a, b);
            ix = pc[5:2];
            if (br_m != 32'hFFFF_FFFF) br_m = br_m + 32'd1;
            if (act) begin
                if (bht_m[ix] != 2'b11) bht_m[ix] = bht_m[ix] + 2'd1;
            end else begin
                if (bht_m[ix] != 2'b00) bht_m[ix] = bht_m[ix] - 2'd1;
            end
            if (act != pred) begin
                if (mis_m != 32'hFFFF_FFFF) mis_m = mis_m + 32'd1;
                exp_q.push_back(act ? pc + imm : pc + 32'd4);
                m_busy = FC + 1;
            end
        end
    endtask

    task automatic drive_br(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b, input logic pred);
        present_br(pc, imm, f3, a, b, pred);
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_valid = 1'b1;
        id_pc = 32'h100;
        ex_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rv: got %b want 0", redirect_valid); end
        n_cmp++;
        if (redirect_pc !== 32'd0) begin n_bad++; $display("FAIL rst_rpc: got %h want 0", redirect_pc); end
        n_cmp++;
        if (flush !== 1'b0) begin n_bad++; $display("FAIL rst_flush: got %b want 0", flush); end
        n_cmp++;
        if (br_count !== 32'd0) begin n_bad++; $display("FAIL rst_br: got %h want 0", br_count); end
        n_cmp++;
        if (mispred_count !== 32'd0) begin n_bad++; $display("FAIL rst_mis: got %h want 0", mispred_count); end
        n_cmp++;
        if (id_pred_taken !== 1'b0) begin n_bad++; $display("FAIL rst_pred: got %b want 0", id_pred_taken); end
        id_valid = 1'b0;
    endtask

    task automatic test_training();
        logic old_p;
        logic [31:0] e;
        id_valid = 1'b1;
        id_pc = 32'h40;
        n_cmp++;
        if (id_pred_taken !== 1'b0) begin n_bad++; $display("FAIL train_init: got %b want 0", id_pred_taken); end
        for (int k = 0; k < 2; k++) begin
            old_p = m_pred(32'h40);
            present_br(32'h40, 32'h18, 3'b001, 32'd1, 32'd2, old_p);
            #2;
            n_cmp++;
            if (id_pred_taken !== old_p) begin
                n_bad++; $display("FAIL train_nobypass%0d: got %b want %b", k, id_pred_taken, old_p);
            end
            tick();
            ex_valid = 1'b0;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (redirect_valid !== 1'b1 || redirect_pc !== e) begin
                    n_bad++; $display("FAIL train_redir%0d: got %b/%h want 1/%h", k, redirect_valid, redirect_pc, e);
                end
            end else begin
                n_cmp++;
                if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL train_noredir%0d: got %b want 0", k, redirect_valid); end
            end
            repeat (FC) tick();
        end
        n_cmp++;
`ifdef BRANCH_CTRL_BHT_EN
        if (id_pred_taken !== 1'b1) begin n_bad++; $display("FAIL train_final: got %b want 1", id_pred_taken); end
`else
        if (id_pred_taken !== 1'b0) begin n_bad++; $display("FAIL train_final: got %b want 0", id_pred_taken); end
`endif
        id_valid = 1'b0;
        #1;
        n_cmp++;
        if (id_pred_taken !== 1'b0) begin n_bad++; $display("FAIL train_gate: got %b want 0", id_pred_taken); end
    endtask

    task automatic test_beq_mispredict();
        logic [31:0] e;
        drive_br(32'h100, 32'h20, 3'b000, 32'd5, 32'd5, 1'b0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== e) begin
            n_bad++; $display("FAIL beq_redir: got %b/%h want 1/%h", redirect_valid, redirect_pc, e);
        end
        n_cmp++;
        if (flush !== 1'b1) begin n_bad++; $display("FAIL beq_flush1: got %b want 1", flush); end
        n_cmp++;
        if (mispred_count !== mis_m) begin n_bad++; $display("FAIL beq_mis: got %h want %h", mispred_count, mis_m); end
        n_cmp++;
        if (br_count !== br_m) begin n_bad++; $display("FAIL beq_br: got %h want %h", br_count, br_m); end
        for (int k = 2; k <= FC; k++) begin
            tick();
            n_cmp++;
            if (flush !== 1'b1 || redirect_valid !== 1'b0) begin
                n_bad++; $display("FAIL beq_hold%0d: got flush %b rv %b want 1 0", k, flush, redirect_valid);
            end
        end
        tick();
        n_cmp++;
        if (flush !== 1'b0) begin n_bad++; $display("FAIL beq_flush_end: got %b want 0", flush); end
    endtask

    task automatic test_signed_unsigned();
        logic [31:0] e;
        drive_br(32'h200, 32'h10, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== e) begin
            n_bad++; $display("FAIL blt_redir: got %b/%h want 1/%h", redirect_valid, redirect_pc, e);
        end
        repeat (FC) tick();
        drive_br(32'h300, 32'h10, 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== e) begin
            n_bad++; $display("FAIL bltu_redir: got %b/%h want 1/%h", redirect_valid, redirect_pc, e);
        end
        repeat (FC) tick();
    endtask

    task automatic test_compare_table();
        logic [2:0]  f3_t [6] = '{3'b001, 3'b101, 3'b111, 3'b000, 3'b100, 3'b110};
        logic [31:0] a_t  [6] = '{32'd3, 32'd1, 32'd1, 32'd7, 32'd1, 32'd1};
        logic [31:0] b_t  [6] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd8, 32'd2, 32'd2};
        logic [31:0] e;
        for (int i = 0; i < 6; i++) begin
            drive_br(32'h400 + 32'(i * 4), 32'h80, f3_t[i], a_t[i], b_t[i], 1'b0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (redirect_valid !== 1'b1 || redirect_pc !== e) begin
                    n_bad++; $display("FAIL cmp%0d_redir: got %b/%h want 1/%h", i, redirect_valid, redirect_pc, e);
                end
            end else begin
                n_cmp++;
                if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL cmp%0d_noredir: got %b want 0", i, redirect_valid); end
            end
            n_cmp++;
            if (br_count !== br_m) begin n_bad++; $display("FAIL cmp%0d_br: got %h want %h", i, br_count, br_m); end
            repeat (FC) tick();
        end
    endtask

    task automatic test_back_to_back();
        drive_br(32'h700, 32'h8, 3'b000, 32'd1, 32'd2, 1'b0);
        n_cmp++;
        if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_0: got %b want 0", redirect_valid); end
        drive_br(32'h704, 32'h8, 3'b001, 32'd1, 32'd1, 1'b0);
        n_cmp++;
        if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_1: got %b want 0", redirect_valid); end
        drive_br(32'h708, 32'h8, 3'b110, 32'd5, 32'd3, 1'b0);
        n_cmp++;
        if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_2: got %b want 0", redirect_valid); end
        n_cmp++;
        if (br_count !== br_m) begin n_bad++; $display("FAIL b2b_br: got %h want %h", br_count, br_m); end
    endtask

    task automatic test_flush_drop();
        logic [31:0] e;
        drive_br(32'h88, 32'h8, 3'b000, 32'd4, 32'd4, m_pred(32'h88));
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== e) begin
            n_bad++; $display("FAIL drop_first: got %b/%h want 1/%h", redirect_valid, redirect_pc, e);
        end
        drive_br(32'h4C, 32'h10, 3'b000, 32'd1, 32'd1, 1'b0);
        n_cmp++;
        if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL drop_redir: got %b want 0", redirect_valid); end
        n_cmp++;
        if (br_count !== br_m) begin n_bad++; $display("FAIL drop_br: got %h want %h", br_count, br_m); end
        repeat (FC) tick();
        n_cmp++;
        if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
            n_bad++; $display("FAIL drop_late: got rv %b flush %b want 0 0", redirect_valid, flush);
        end
        id_valid = 1'b1;
        id_pc = 32'h4C;
        #1;
        n_cmp++;
        if (id_pred_taken !== 1'b0) begin n_bad++; $display("FAIL drop_bht: got %b want 0", id_pred_taken); end
        id_valid = 1'b0;
    endtask

    task automatic test_illegal_wrap();
        logic [31:0] e;
        drive_br(32'h4C, 32'h10, 3'b010, 32'd1, 32'd1, 1'b0);
        drive_br(32'h4C, 32'h10, 3'b011, 32'd1, 32'd1, 1'b0);
        n_cmp++;
        if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
            n_bad++; $display("FAIL ill_redir: got rv %b flush %b want 0 0", redirect_valid, flush);
        end
        n_cmp++;
        if (br_count !== br_m) begin n_bad++; $display("FAIL ill_br: got %h want %h", br_count, br_m); end
        n_cmp++;
        if (mispred_count !== mis_m) begin n_bad++; $display("FAIL ill_mis: got %h want %h", mispred_count, mis_m); end
        id_valid = 1'b1;
        id_pc = 32'h4C;
        #1;
        n_cmp++;
        if (id_pred_taken !== 1'b0) begin n_bad++; $display("FAIL ill_bht: got %b want 0", id_pred_taken); end
        id_valid = 1'b0;
        drive_br(32'hFFFF_FFF0, 32'h20, 3'b000, 32'd9, 32'd9, m_pred(32'hFFFF_FFF0));
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== e) begin
            n_bad++; $display("FAIL wrap_redir: got %b/%h want 1/%h", redirect_valid, redirect_pc, e);
        end
        repeat (FC) tick();
    endtask

    task automatic test_reset_midflush();
        logic [31:0] e;
        drive_br(32'h500, 32'h40, 3'b001, 32'd1, 32'd2, 1'b0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== e) begin
            n_bad++; $display("FAIL mid_redir: got %b/%h want 1/%h", redirect_valid, redirect_pc, e);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if (flush !== 1'b0 || redirect_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid_abort: got flush %b rv %b want 0 0", flush, redirect_valid);
        end
        n_cmp++;
        if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
            n_bad++; $display("FAIL mid_counts: got %h/%h want 0/0", br_count, mispred_count);
        end
        id_valid = 1'b1;
        id_pc = 32'h40;
        #1;
        n_cmp++;
        if (id_pred_taken !== 1'b0) begin n_bad++; $display("FAIL mid_bht: got %b want 0", id_pred_taken); end
        id_valid = 1'b0;
        drive_br(32'h600, 32'h100, 3'b000, 32'd3, 32'd3, 1'b0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== e) begin
            n_bad++; $display("FAIL mid_resume: got %b/%h want 1/%h", redirect_valid, redirect_pc, e);
        end
        repeat (FC) tick();
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0;
        id_pc = 32'd0;
        ex_valid = 1'b0;
        ex_pc = 32'd0;
        ex_imm = 32'd0;
        ex_funct3 = 3'b000;
        ex_rs1 = 32'd0;
        ex_rs2 = 32'd0;
        ex_pred_taken = 1'b0;
        model_reset();
        test_reset();
        test_training();
        test_beq_mispredict();
        test_signed_unsigned();
        test_compare_table();
        test_back_to_back();
        test_flush_drop();
        test_illegal_wrap();
        test_reset_midflush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
